// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Raster timing generator for the 640x480 @ 60 Hz display path.
//            Free-running pixel/line counters are decoded into DrawX/DrawY,
//            blank, active-low hs/vs, frame/line markers and a frame counter.
//            Every output is registered from the same pre-increment counter
//            state, so all outputs describe the same pixel in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,  // visible pixels per line
    parameter int H_FP      = 16,   // horizontal front porch
    parameter int H_SYNC    = 96,   // horizontal sync width
    parameter int H_BP      = 48,   // horizontal back porch
    parameter int V_VISIBLE = 480,  // visible lines per frame
    parameter int V_FP      = 10,   // vertical front porch
    parameter int V_SYNC    = 2,    // vertical sync width
    parameter int V_BP      = 33    // vertical back porch
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic       line_end,
    output logic [7:0] frame_count
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int c_h_total = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide, so neither total may exceed 1024.
    generate
        if (c_h_total > 1024) begin : g_h_total_check
            $error("vga_timing_gen: horizontal total exceeds 1024");
        end
        if (c_v_total > 1024) begin : g_v_total_check
            $error("vga_timing_gen: vertical total exceeds 1024");
        end
    endgenerate

    localparam logic [9:0]  c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last     = 10'(c_v_total - 1);
    localparam logic [9:0]  c_hs_first   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  c_hs_last    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  c_vs_first   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  c_vs_last    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    // Visible widths may legally equal 1024, so compare them at 11 bits.
    localparam logic [10:0] c_h_visible  = 11'(H_VISIBLE);
    localparam logic [10:0] c_v_visible  = 11'(V_VISIBLE);

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic [9:0] w_hc_next;
    logic [9:0] w_vc_next;
    logic       w_h_last;
    logic       w_v_last;

    assign w_h_last = (r_hc == c_h_last);
    assign w_v_last = (r_vc == c_v_last);

    // Next-count logic: hc wraps at end of line, vc advances only on that wrap.
    always_comb begin
        w_hc_next = r_hc + 10'd1;
        w_vc_next = r_vc;
        if (w_h_last) begin
            w_hc_next = 10'd0;
            if (w_v_last) begin
                w_vc_next = 10'd0;
            end else begin
                w_vc_next = r_vc + 10'd1;
            end
        end
    end

    // Counter registers; a reset always restarts the raster at (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc <= 10'd0;
            r_vc <= 10'd0;
        end else begin
            r_hc <= w_hc_next;
            r_vc <= w_vc_next;
        end
    end

    // ------------------------------------------------------------------------
    // Decode of the current (pre-increment) counter state
    // ------------------------------------------------------------------------
    logic w_hs_active;
    logic w_vs_active;
    logic w_visible;
    logic w_frame_start;

    assign w_hs_active   = (r_hc >= c_hs_first) && (r_hc <= c_hs_last);
    assign w_vs_active   = (r_vc >= c_vs_first) && (r_vc <= c_vs_last);
    assign w_visible     = ({1'b0, r_hc} < c_h_visible) &&
                           ({1'b0, r_vc} < c_v_visible);
    assign w_frame_start = (r_hc == 10'd0) && (r_vc == 10'd0);

    // ------------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------------
    // All outputs load from the same counter snapshot to stay pixel-aligned.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            DrawX       <= r_hc;
            DrawY       <= r_vc;
            hs          <= ~w_hs_active;
            vs          <= ~w_vs_active;
            blank       <= w_visible;
            frame_start <= w_frame_start;
            line_end    <= w_h_last;
        end
    end

    // Frame counter steps on the same edge that raises frame_start, so the
    // new count is visible in the first cycle of its frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 8'd0;
        end else if (w_frame_start) begin
            frame_count <= frame_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench. Instance A uses the default 640x480 timing
//            for reset and line-level vectors; instance B uses a reduced
//            raster (15x10) so frame wrap, mid-frame reset and 256-frame
//            counter wrap fit in a short run. B is compared every cycle
//            against an arithmetic pixel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;

    always #5 clk = ~clk;

    // Instance A: default timing
    logic       a_hs, a_vs, a_blank, a_fs, a_le;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;

    vga_timing_gen dut_a (
        .vga_clk     (clk),
        .reset_n     (rst_n_a),
        .hs          (a_hs),
        .vs          (a_vs),
        .blank       (a_blank),
        .DrawX       (a_x),
        .DrawY       (a_y),
        .frame_start (a_fs),
        .line_end    (a_le),
        .frame_count (a_fc)
    );

    // Instance B: reduced timing, H: 8+2+3+2=15, V: 6+1+2+1=10
    logic       b_hs, b_vs, b_blank, b_fs, b_le;
    logic [9:0] b_x, b_y;
    logic [7:0] b_fc;

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_b (
        .vga_clk     (clk),
        .reset_n     (rst_n_b),
        .hs          (b_hs),
        .vs          (b_vs),
        .blank       (b_blank),
        .DrawX       (b_x),
        .DrawY       (b_y),
        .frame_start (b_fs),
        .line_end    (b_le),
        .frame_count (b_fc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Model for instance B: hs low x=10..12, vs low y=7..8, visible x<8,y<6
    // ------------------------------------------------------------------------
    int nb = 0;  // edges since B's reset release; pixel index is nb-1

    always @(posedge clk) begin
        if (!rst_n_b) nb <= 0;
        else          nb <= nb + 1;
    end

    always @(negedge clk) begin
        int p, x, y, f;
        if (!rst_n_b || nb == 0) begin
            chk("B_rst_DrawX", int'(b_x), 0);
            chk("B_rst_DrawY", int'(b_y), 0);
            chk("B_rst_hs", int'(b_hs), 1);
            chk("B_rst_vs", int'(b_vs), 1);
            chk("B_rst_blank", int'(b_blank), 0);
            chk("B_rst_fs", int'(b_fs), 0);
            chk("B_rst_le", int'(b_le), 0);
            chk("B_rst_fc", int'(b_fc), 0);
        end else begin
            p = nb - 1;
            x = p % 15;
            y = (p / 15) % 10;
            f = p / 150;
            chk("B_DrawX", int'(b_x), x);
            chk("B_DrawY", int'(b_y), y);
            chk("B_hs", int'(b_hs), (x >= 10 && x <= 12) ? 0 : 1);
            chk("B_vs", int'(b_vs), (y >= 7 && y <= 8) ? 0 : 1);
            chk("B_blank", int'(b_blank), (x < 8 && y < 6) ? 1 : 0);
            chk("B_fs", int'(b_fs), (x == 0 && y == 0) ? 1 : 0);
            chk("B_le", int'(b_le), (x == 14) ? 1 : 0);
            chk("B_fc", int'(b_fc), (f + 1) % 256);
        end
    end

    // ------------------------------------------------------------------------
    // Vector table for instance A (cycle = edges since release)
    // ------------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic [9:0] x, y;
        logic       hs, vs, blank, fs, le;
        logic [7:0] fc;
    } vec_t;

    function automatic vec_t mk(int c, int x, int y, int hs, int vs,
                                int bl, int fs, int le, int fc);
        vec_t v;
        v.cyc = c; v.x = 10'(x); v.y = 10'(y);
        v.hs = 1'(hs); v.vs = 1'(vs); v.blank = 1'(bl);
        v.fs = 1'(fs); v.le = 1'(le); v.fc = 8'(fc);
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        int idx, blank_cnt, hs_lo, le1, le2, vs_lo, fsn, last_fs, found;

        //             cyc   X    Y  hs vs bl fs le fc
        tbl[0]  = mk(   1,   0,   0, 1, 1, 1, 1, 0, 1);
        tbl[1]  = mk( 640, 639,   0, 1, 1, 1, 0, 0, 1);
        tbl[2]  = mk( 641, 640,   0, 1, 1, 0, 0, 0, 1);
        tbl[3]  = mk( 656, 655,   0, 1, 1, 0, 0, 0, 1);
        tbl[4]  = mk( 657, 656,   0, 0, 1, 0, 0, 0, 1);
        tbl[5]  = mk( 752, 751,   0, 0, 1, 0, 0, 0, 1);
        tbl[6]  = mk( 753, 752,   0, 1, 1, 0, 0, 0, 1);
        tbl[7]  = mk( 799, 798,   0, 1, 1, 0, 0, 0, 1);
        tbl[8]  = mk( 800, 799,   0, 1, 1, 0, 0, 1, 1);
        tbl[9]  = mk( 801,   0,   1, 1, 1, 1, 0, 0, 1);
        tbl[10] = mk(1600, 799,   1, 1, 1, 0, 0, 1, 1);
        tbl[11] = mk(1601,   0,   2, 1, 1, 1, 0, 0, 1);

        // Reset held 10 cycles: A must sit at reset values throughout
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("A_rst_DrawX", int'(a_x), 0);
            chk("A_rst_DrawY", int'(a_y), 0);
            chk("A_rst_hs", int'(a_hs), 1);
            chk("A_rst_vs", int'(a_vs), 1);
            chk("A_rst_blank", int'(a_blank), 0);
            chk("A_rst_fs", int'(a_fs), 0);
            chk("A_rst_le", int'(a_le), 0);
            chk("A_rst_fc", int'(a_fc), 0);
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Two full lines of A: table vectors plus per-line aggregates
        idx = 0; blank_cnt = 0; hs_lo = 0; le1 = 0; le2 = 0;
        for (int k = 1; k <= 1601; k++) begin
            tick();
            if (k <= 800) begin
                blank_cnt += int'(a_blank);
                hs_lo     += int'(!a_hs);
                le1       += int'(a_le);
            end else if (k <= 1600) begin
                le2 += int'(a_le);
            end
            if (idx < 12 && tbl[idx].cyc == k) begin
                chk($sformatf("A_v%0d_DrawX", idx), int'(a_x), int'(tbl[idx].x));
                chk($sformatf("A_v%0d_DrawY", idx), int'(a_y), int'(tbl[idx].y));
                chk($sformatf("A_v%0d_hs", idx), int'(a_hs), int'(tbl[idx].hs));
                chk($sformatf("A_v%0d_vs", idx), int'(a_vs), int'(tbl[idx].vs));
                chk($sformatf("A_v%0d_blank", idx), int'(a_blank), int'(tbl[idx].blank));
                chk($sformatf("A_v%0d_fs", idx), int'(a_fs), int'(tbl[idx].fs));
                chk($sformatf("A_v%0d_le", idx), int'(a_le), int'(tbl[idx].le));
                chk($sformatf("A_v%0d_fc", idx), int'(a_fc), int'(tbl[idx].fc));
                idx++;
            end
        end
        chk("A_line_blank_cycles", blank_cnt, 640);
        chk("A_line_hs_low_cycles", hs_lo, 96);
        chk("A_line0_le_pulses", le1, 1);
        chk("A_line1_le_pulses", le2, 1);

        // B: asynchronous reset between edges at pixel (5,4)
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (b_x == 10'd5 && b_y == 10'd4) found = 1;
            else tick();
        end
        chk("B_seek_5_4", found, 1);
        #1 rst_n_b = 1'b0;
        #1;
        chk("B_async_DrawX", int'(b_x), 0);
        chk("B_async_DrawY", int'(b_y), 0);
        chk("B_async_hs", int'(b_hs), 1);
        chk("B_async_blank", int'(b_blank), 0);
        chk("B_async_fc", int'(b_fc), 0);
        @(negedge clk);
        tick();
        tick();
        rst_n_b = 1'b1;
        tick();
        chk("B_restart_DrawX", int'(b_x), 0);
        chk("B_restart_DrawY", int'(b_y), 0);
        chk("B_restart_fs", int'(b_fs), 1);
        chk("B_restart_fc", int'(b_fc), 1);

        // B: 256 more frames; period and frame_count at every frame_start
        fsn = 1; last_fs = 0; vs_lo = 0;
        for (int c = 1; c <= 256 * 150 + 5; c++) begin
            tick();
            if (c < 150) vs_lo += int'(!b_vs);
            if (b_fs) begin
                fsn++;
                chk("B_frame_period", c - last_fs, 150);
                chk("B_frame_count", int'(b_fc), fsn % 256);
                last_fs = c;
            end
        end
        chk("B_vs_low_cycles", vs_lo, 30);
        chk("B_frame_starts", fsn, 257);
        chk("B_final_fc", int'(b_fc), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
